// File: rtl/ysyx_24070016_mem_arbiter.sv
// Two-requester (IFU/LSU) round-robin arbiter and sequencer for the
// single-ported data memory.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   ifu_req_*/resp_*  IFU valid/ready request (read-only word) and response
//   lsu_req_*/resp_*  LSU valid/ready request (sized load/store) and response
//   mem_*             memory port: one-cycle mem_valid strobe, held fields,
//                     mem_rdata valid MEM_LAT cycles after the strobe
module ysyx_24070016_mem_arbiter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_wren,
  input  logic [2:0]  lsu_op,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,
  output logic        mem_valid,
  output logic        mem_wren,
  output logic [2:0]  mem_op,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_t      r_state;
  state_t      w_next;
  logic        r_last;
  logic        r_owner;
  logic        r_wren;
  logic [2:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [3:0]  r_cnt;
  logic        w_pick_lsu;
  logic        w_any_req;

  // On a tie the requester that did not win last time gets the grant.
  assign w_any_req  = ifu_req_valid | lsu_req_valid;
  assign w_pick_lsu = lsu_req_valid
                    & (~ifu_req_valid | (r_last == OWN_IFU));

  assign mem_wren  = r_wren;
  assign mem_op    = r_op;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    ifu_rdata      = 32'h0;
    lsu_rdata      = 32'h0;
    mem_valid      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        ifu_req_ready = ifu_req_valid & ~w_pick_lsu;
        lsu_req_ready = w_pick_lsu;
        if (w_any_req) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        mem_valid = 1'b1;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) w_next = S_RESP;
      end
      S_RESP: begin
        if (r_owner == OWN_LSU) begin
          lsu_resp_valid = 1'b1;
          lsu_rdata      = r_rdata;
          if (lsu_resp_ready) w_next = S_IDLE;
        end else begin
          ifu_resp_valid = 1'b1;
          ifu_rdata      = r_rdata;
          if (ifu_resp_ready) w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= OWN_LSU;
      r_owner <= OWN_IFU;
      r_wren  <= 1'b0;
      r_op    <= 3'b000;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_cnt   <= 4'd0;
    end else begin
      if (r_state == S_IDLE && w_any_req) begin
        r_owner <= w_pick_lsu;
        r_last  <= w_pick_lsu;
        if (w_pick_lsu) begin
          r_wren  <= lsu_wren;
          r_op    <= lsu_op;
          r_addr  <= lsu_addr;
          r_wdata <= lsu_wdata;
        end else begin
          r_wren  <= 1'b0;
          r_op    <= 3'b010;
          r_addr  <= ifu_addr;
          r_wdata <= 32'h0;
        end
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= 4'(MEM_LAT);
      end
      if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
        // Stores acknowledge with zero data.
        if (r_cnt == 4'd1) begin
          r_rdata <= r_wren ? 32'h0 : mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24070016_mem_arbiter.sv
// Directed bench for ysyx_24070016_mem_arbiter: one instance with
// MEM_LAT=1 (main sequence) and one with MEM_LAT=3 (latency check).
module tb_ysyx_24070016_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        ifu_req_valid = 0, ifu_req_ready;
  logic [31:0] ifu_addr = 0;
  logic        ifu_resp_valid, ifu_resp_ready = 0;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid = 0, lsu_req_ready;
  logic        lsu_wren = 0;
  logic [2:0]  lsu_op = 0;
  logic [31:0] lsu_addr = 0, lsu_wdata = 0;
  logic        lsu_resp_valid, lsu_resp_ready = 0;
  logic [31:0] lsu_rdata;
  logic        mem_valid, mem_wren;
  logic [2:0]  mem_op;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;

  logic        b_ifu_req_ready, b_ifu_resp_valid;
  logic [31:0] b_ifu_rdata;
  logic        b_lsu_req_valid = 0, b_lsu_req_ready;
  logic        b_lsu_wren = 0;
  logic [2:0]  b_lsu_op = 0;
  logic [31:0] b_lsu_addr = 0;
  logic        b_lsu_resp_valid, b_lsu_resp_ready = 0;
  logic [31:0] b_lsu_rdata;
  logic        b_mem_valid, b_mem_wren;
  logic [2:0]  b_mem_op;
  logic [31:0] b_mem_addr, b_mem_wdata;
  logic [31:0] b_mem_rdata = 0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_24070016_mem_arbiter #(.MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_wren(lsu_wren), .lsu_op(lsu_op),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_rdata(lsu_rdata),
    .mem_valid(mem_valid), .mem_wren(mem_wren), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  ysyx_24070016_mem_arbiter #(.MEM_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(1'b0), .ifu_req_ready(b_ifu_req_ready),
    .ifu_addr(32'h0),
    .ifu_resp_valid(b_ifu_resp_valid), .ifu_resp_ready(1'b0),
    .ifu_rdata(b_ifu_rdata),
    .lsu_req_valid(b_lsu_req_valid), .lsu_req_ready(b_lsu_req_ready),
    .lsu_wren(b_lsu_wren), .lsu_op(b_lsu_op),
    .lsu_addr(b_lsu_addr), .lsu_wdata(32'h0),
    .lsu_resp_valid(b_lsu_resp_valid), .lsu_resp_ready(b_lsu_resp_ready),
    .lsu_rdata(b_lsu_rdata),
    .mem_valid(b_mem_valid), .mem_wren(b_mem_wren), .mem_op(b_mem_op),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bit ifu_turn;

    // Reset state
    #12;
    chk("rst_ifu_req_ready", ifu_req_ready, 0);
    chk("rst_lsu_req_ready", lsu_req_ready, 0);
    chk("rst_ifu_resp_valid", ifu_resp_valid, 0);
    chk("rst_lsu_resp_valid", lsu_resp_valid, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_b_mem_valid", b_mem_valid, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Single IFU read, MEM_LAT=1
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
    #1;
    chk("ifu_rd_req_ready", ifu_req_ready, 1);
    chk("ifu_rd_lsu_ready", lsu_req_ready, 0);
    cyc();
    ifu_req_valid = 0; mem_rdata = 32'hBAD0_0001;
    chk("ifu_rd_mem_valid", mem_valid, 1);
    chk("ifu_rd_mem_op", mem_op, 3'b010);
    chk("ifu_rd_mem_wren", mem_wren, 0);
    chk("ifu_rd_mem_addr", mem_addr, 32'h8000_0000);
    cyc();
    mem_rdata = 32'h0000_0413;
    chk("ifu_rd_wait_mv", mem_valid, 0);
    chk("ifu_rd_wait_rv", ifu_resp_valid, 0);
    cyc();
    mem_rdata = 32'hBAD0_0002; ifu_resp_ready = 1;
    chk("ifu_rd_resp_valid", ifu_resp_valid, 1);
    chk("ifu_rd_rdata", ifu_rdata, 32'h0000_0413);
    chk("ifu_rd_lsu_rv", lsu_resp_valid, 0);
    cyc();
    ifu_resp_ready = 0;
    chk("ifu_rd_resp_drop", ifu_resp_valid, 0);

    // LSU store
    lsu_req_valid = 1; lsu_wren = 1; lsu_op = 3'b000;
    lsu_addr = 32'h8000_1000; lsu_wdata = 32'h0000_00AB;
    #1;
    chk("st_req_ready", lsu_req_ready, 1);
    cyc();
    lsu_req_valid = 0; mem_rdata = 32'h5555_5555;
    chk("st_mem_valid", mem_valid, 1);
    chk("st_mem_wren", mem_wren, 1);
    chk("st_mem_op", mem_op, 3'b000);
    chk("st_mem_wdata", mem_wdata, 32'h0000_00AB);
    chk("st_mem_addr", mem_addr, 32'h8000_1000);
    cyc();
    chk("st_wait_mv", mem_valid, 0);
    chk("st_wdata_held", mem_wdata, 32'h0000_00AB);
    cyc();
    lsu_resp_ready = 1;
    chk("st_resp_valid", lsu_resp_valid, 1);
    chk("st_rdata_zero", lsu_rdata, 0);
    chk("st_ifu_rv", ifu_resp_valid, 0);
    cyc();
    lsu_resp_ready = 0; lsu_wren = 0;
    chk("st_resp_drop", lsu_resp_valid, 0);

    // Reset mid-WAIT drops the transaction
    ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
    #1;
    chk("rw_req_ready", ifu_req_ready, 1);
    cyc();
    ifu_req_valid = 0;
    cyc();
    ifu_resp_ready = 1;
    rst_n = 0;
    #1;
    chk("rw_mem_valid", mem_valid, 0);
    chk("rw_mem_addr", mem_addr, 0);
    chk("rw_ifu_rv", ifu_resp_valid, 0);
    chk("rw_ifu_rdata", ifu_rdata, 0);
    cyc();
    rst_n = 1;
    cyc();
    chk("rw_no_stale1", ifu_resp_valid, 0);
    cyc();
    chk("rw_no_stale2", ifu_resp_valid, 0);
    chk("rw_idle_mv", mem_valid, 0);

    // Simultaneous requests: IFU, LSU, IFU, LSU
    ifu_req_valid = 1; ifu_addr = 32'h8000_00A0;
    lsu_req_valid = 1; lsu_op = 3'b010; lsu_addr = 32'h8000_00B0;
    ifu_resp_ready = 1; lsu_resp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      ifu_turn = (k % 2 == 0);
      #1;
      chk("rr_ifu_ready", ifu_req_ready, ifu_turn);
      chk("rr_lsu_ready", lsu_req_ready, !ifu_turn);
      cyc();
      chk("rr_mem_valid", mem_valid, 1);
      chk("rr_mem_addr", mem_addr,
          ifu_turn ? 32'h8000_00A0 : 32'h8000_00B0);
      mem_rdata = 32'h0000_1000 + k;
      cyc();
      cyc();
      chk("rr_ifu_rv", ifu_resp_valid, ifu_turn);
      chk("rr_lsu_rv", lsu_resp_valid, !ifu_turn);
      chk("rr_rdata", ifu_turn ? ifu_rdata : lsu_rdata,
          32'h0000_1000 + k);
      cyc();
    end

    // Response backpressure with a pending IFU request
    ifu_req_valid = 0; ifu_resp_ready = 0; lsu_resp_ready = 0;
    lsu_addr = 32'h8000_00C0;
    #1;
    chk("bp_lsu_ready", lsu_req_ready, 1);
    cyc();
    lsu_req_valid = 0;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0300;
    cyc();
    mem_rdata = 32'hCAFE_F00D;
    #1;
    chk("bp_wait_ifu_ready", ifu_req_ready, 0);
    cyc();
    mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold_rv", lsu_resp_valid, 1);
      chk("bp_hold_rdata", lsu_rdata, 32'hCAFE_F00D);
      chk("bp_hold_ifu_ready", ifu_req_ready, 0);
      cyc();
      mem_rdata = 32'h0000_0070 + i;
    end
    lsu_resp_ready = 1;
    #1;
    chk("bp_hs_rv", lsu_resp_valid, 1);
    chk("bp_hs_ifu_ready", ifu_req_ready, 0);
    cyc();
    lsu_resp_ready = 0;
    #1;
    chk("bp_after_rv", lsu_resp_valid, 0);
    chk("bp_after_ifu_ready", ifu_req_ready, 1);
    cyc();
    ifu_req_valid = 0;
    chk("bp_ifu_mem_valid", mem_valid, 1);
    chk("bp_ifu_mem_addr", mem_addr, 32'h8000_0300);

    // MEM_LAT=3 single load
    b_lsu_req_valid = 1; b_lsu_wren = 0; b_lsu_op = 3'b100;
    b_lsu_addr = 32'h8000_2003;
    #1;
    chk("l3_req_ready", b_lsu_req_ready, 1);
    cyc();
    b_lsu_req_valid = 0; b_mem_rdata = 32'h0000_0011;
    chk("l3_mem_valid", b_mem_valid, 1);
    chk("l3_mem_op", b_mem_op, 3'b100);
    chk("l3_mem_addr", b_mem_addr, 32'h8000_2003);
    cyc();
    b_mem_rdata = 32'h0000_0022;
    chk("l3_t2_mv", b_mem_valid, 0);
    cyc();
    b_mem_rdata = 32'h0000_0033;
    chk("l3_t3_rv", b_lsu_resp_valid, 0);
    cyc();
    b_mem_rdata = 32'h0000_00EE;
    chk("l3_t4_rv", b_lsu_resp_valid, 0);
    cyc();
    b_mem_rdata = 32'h0000_0055;
    chk("l3_t5_rv", b_lsu_resp_valid, 1);
    chk("l3_t5_rdata", b_lsu_rdata, 32'h0000_00EE);
    chk("l3_ifu_rv", b_ifu_resp_valid, 0);
    cyc();
    b_lsu_resp_ready = 1;
    chk("l3_t6_rdata", b_lsu_rdata, 32'h0000_00EE);
    cyc();
    b_lsu_resp_ready = 0;
    chk("l3_done_rv", b_lsu_resp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_24070016_mem_arbiter.md
Name: ysyx_24070016_mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-ported data-memory block.
- Requesters are the instruction-fetch unit (IFU, read-only, word) and the load/store unit (LSU, read/write, sized).
- Accepts one request at a time via valid/ready, drives the memory port for exactly one cycle, waits the fixed memory latency, then returns a registered response via valid/ready.
- Round-robin between requesters on simultaneous requests.

Parameters:
- MEM_LAT, 1, cycles from the mem_valid cycle to the cycle in which mem_rdata is valid; legal range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ifu_req_valid  in  1  IFU request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  32  IFU fetch address
- ifu_resp_valid  out  1  IFU response available
- ifu_resp_ready  in  1  IFU consumes response
- ifu_rdata  out  32  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_wren  in  1  1 = store, 0 = load
- lsu_op  in  3  size/sign code (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu)
- lsu_addr  in  32  LSU address
- lsu_wdata  in  32  store data
- lsu_resp_valid  out  1  LSU response available (load data or store ack)
- lsu_resp_ready  in  1  LSU consumes response
- lsu_rdata  out  32  LSU load data (0 for stores)
- mem_valid  out  1  memory request strobe, one cycle per transaction
- mem_wren  out  1  memory write enable
- mem_op  out  3  memory size/sign code
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, already sign/zero-extended by the memory block

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=LSU.
  - All outputs 0: req_ready, resp_valid, rdata, mem_*.
  - Any in-flight transaction is dropped; no response is ever issued for it.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready is combinational: asserted only in IDLE, only to the winner.
  - Winner: the single requester if only one is valid; if both are valid, the one not in last_grant.
  - On acceptance: latch owner, wren, op, addr, wdata; update last_grant=owner; next state ISSUE.
  - IFU requests are latched as wren=0, op=010.
- ISSUE (1 cycle):
  - mem_valid=1; mem_wren/op/addr/wdata driven from the latched fields.
  - Load wait counter with MEM_LAT; next state WAIT.
- WAIT:
  - mem_valid=0; counter decrements each cycle.
  - In the cycle the counter equals 1, register resp_data = (wren ? 0 : mem_rdata) and go to RESP.
  - WAIT therefore lasts exactly MEM_LAT cycles.
- RESP:
  - Owner's resp_valid=1; owner's rdata=resp_data, held stable while resp_valid is high.
  - When the owner's resp_ready=1: go to IDLE. resp_valid falls next cycle.
  - No new request is accepted in RESP. The earliest next accept is the cycle after the handshake.
- Timing: accept at cycle T → mem_valid at T+1 → resp_valid from T+2+MEM_LAT. Back-to-back throughput is one transaction per 3+MEM_LAT cycles with resp_ready tied high.
- Outputs not belonging to the current owner stay 0: the non-owner's resp_valid, rdata and req_ready.
- mem_* fields are held at the latched values outside ISSUE; only mem_valid strobes.
- Requesters hold request fields stable while req_valid=1 and ready=0. A req_valid drop before acceptance is legal; the request is simply not taken.
- resp_ready asserted while resp_valid=0 is ignored.

Test Plan:
- Reset state: rst_n low mid-WAIT, then release → all outputs 0, state IDLE; next request behaves as from fresh reset, and no stale response is issued.
- Single IFU read, MEM_LAT=1:
  - Stimulus: ifu_addr=0x80000000 at T, memory returns 0x00000413, resp_ready=1.
  - Required: ifu_req_ready at T; mem_valid=1, mem_op=010, mem_wren=0 at T+1; ifu_resp_valid with rdata=0x00000413 at T+3.
- LSU store:
  - Stimulus: lsu_wren=1, op=000, addr=0x80001000, wdata=0xAB.
  - Required: mem_valid one cycle with mem_wren=1, mem_op=000, wdata=0xAB; lsu_resp_valid with lsu_rdata=0.
- Simultaneous requests held continuously after reset:
  - Required grant order IFU, LSU, IFU, LSU; each mem_valid pulse carries the matching address.
- Response backpressure:
  - Stimulus: lsu_resp_ready low for 5 cycles in RESP.
  - Required: lsu_resp_valid and lsu_rdata held stable; pending IFU request not accepted until the cycle after the LSU handshake.
- MEM_LAT=3:
  - Stimulus: single load.
  - Required: mem_rdata sampled 3 cycles after the mem_valid cycle; resp_valid at T+5; values presented at other cycles never appear in rdata.
